oam_dma: RTL and testbench



---
 rtl/oam_dma_if.sv | 25 ++
 rtl/oam_dma.sv | 95 +++++++++
 tb/tb_oam_dma.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// OAM DMA bus bundle: trigger from the PPU register file, source read port, OAM write port and
// lock outputs. master = register file / memory map side, slave = DMA engine.
interface oam_dma_if;
  logic        cpu_en;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  src_rdata;
  logic [15:0] src_addr;
  logic        src_read;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic        active;
  logic        cpu_bus_block;

  modport master (
    output cpu_en, start, start_addr, src_rdata,
    input  src_addr, src_read, oam_addr, oam_wdata, oam_write, active, cpu_bus_block
  );

  modport slave (
    input  cpu_en, start, start_addr, src_rdata,
    output src_addr, src_read, oam_addr, oam_wdata, oam_write, active, cpu_bus_block
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_BYTES bytes from page {start_addr, 00} into OAM, one byte per step.
// Define OAMDMA_BUS_CONFLICT_EN to drive cpu_bus_block from active; otherwise it is tied to 0.
module oam_dma #(
  parameter int unsigned OAM_BYTES = 160
) (
  input  logic       clk,
  input  logic       reset,
  oam_dma_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StStart, StCopy} state_e;

  localparam logic [7:0] LastIdx = 8'(OAM_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       last;
  logic       restart;

  assign last = (idx_q == LastIdx);
  // A trigger on the final COPY step is dropped so the last byte always lands.
  assign restart = bus.cpu_en && bus.start &&
                   ((state_q == StStart) || ((state_q == StCopy) && !last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    if (bus.cpu_en) begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            page_d  = bus.start_addr;
            idx_d   = 8'h00;
            state_d = StStart;
          end
        end
        StStart: begin
          if (restart) begin
            page_d = bus.start_addr;
            idx_d  = 8'h00;
          end else begin
            state_d = StCopy;
          end
        end
        StCopy: begin
          if (restart) begin
            page_d  = bus.start_addr;
            idx_d   = 8'h00;
            state_d = StStart;
          end else if (last) begin
            idx_d   = 8'h00;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 8'h01;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.src_addr  = 16'h0000;
    bus.src_read  = 1'b0;
    bus.oam_write = 1'b0;
    bus.oam_addr  = idx_q;
    bus.oam_wdata = bus.src_rdata;
    bus.active    = (state_q != StIdle);
    if (state_q == StCopy) begin
      bus.src_addr  = {page_q, idx_q};
      bus.src_read  = 1'b1;
      bus.oam_write = bus.cpu_en && !restart;
    end
`ifdef OAMDMA_BUS_CONFLICT_EN
    bus.cpu_bus_block = bus.active;
`else
    bus.cpu_bus_block = 1'b0;
`endif
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected OAM writes are queued as transfers are triggered and
// popped as the DUT strobes oam_write.
module tb_oam_dma;

  logic clk;
  logic reset;

  oam_dma_if bus ();

  oam_dma #(.OAM_BYTES(160)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory model; page C0 holds i ^ 5A.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC0;
  endfunction

  assign bus.src_rdata = mem_byte(bus.src_addr);

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned gate     = 1;
  int unsigned clk_cnt  = 0;
  int unsigned wr_cnt   = 0;
  int unsigned act_cnt  = 0;
  logic        last_wr  = 1'b0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_page(input logic [7:0] page, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back({page, 8'(i), 8'(i), mem_byte({page, 8'(i)})});
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    logic        exp_block;
`ifdef OAMDMA_BUS_CONFLICT_EN
    exp_block = bus.active;
`else
    exp_block = 1'b0;
`endif
    check("bus_block", 32'(bus.cpu_bus_block), 32'(exp_block));
    last_wr = bus.oam_write;
    if (bus.oam_write) begin
      check("wr_on_step", 32'(bus.cpu_en), 32'd1);
      if (sb.size() == 0) begin
        check("sb_pending", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("src_addr", 32'(bus.src_addr), 32'(e[31:16]));
        check("oam_addr", 32'(bus.oam_addr), 32'(e[15:8]));
        check("oam_wdata", 32'(bus.oam_wdata), 32'(e[7:0]));
      end
      wr_cnt++;
    end
    if (bus.cpu_en && bus.active && !reset) act_cnt++;
  endtask

  task automatic cycle(input logic en, input logic st, input logic [7:0] sa, input logic rst);
    bus.cpu_en     = en;
    bus.start      = st;
    bus.start_addr = sa;
    reset          = rst;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    clk_cnt++;
  endtask

  task automatic do_step(input logic st, input logic [7:0] sa);
    for (int i = 1; i < int'(gate); i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, st, sa, 1'b0);
  endtask

  task automatic run_until_idle(input int unsigned max);
    int unsigned n = 0;
    while (bus.active && n < max) begin
      do_step(1'b0, 8'h00);
      n++;
    end
    if (bus.active) check("timeout_idle", 32'(bus.active), 32'd0);
  endtask

  task automatic run_until_writes(input int unsigned target, input int unsigned max);
    int unsigned n = 0;
    while (wr_cnt < target && n < max) begin
      do_step(1'b0, 8'h00);
      n++;
    end
    if (wr_cnt < target) check("timeout_writes", wr_cnt, target);
  endtask

  initial begin
    int unsigned w0, a0, t0;
    bus.cpu_en     = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = 8'h00;
    reset          = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_src_read", 32'(bus.src_read), 32'd0);
    check("rst_src_addr", 32'(bus.src_addr), 32'd0);
    check("rst_oam_addr", 32'(bus.oam_addr), 32'd0);
    check("rst_oam_write", 32'(bus.oam_write), 32'd0);
    check("rst_bus_block", 32'(bus.cpu_bus_block), 32'd0);

    // Basic copy from page C0.
    w0 = wr_cnt; a0 = act_cnt;
    push_page(8'hC0, 160);
    do_step(1'b1, 8'hC0);
    check("basic_active_rise", 32'(bus.active), 32'd1);
    run_until_idle(400);
    check("basic_writes", wr_cnt - w0, 32'd160);
    check("basic_active_steps", act_cnt - a0, 32'd161);
    check("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Step gating: one enabled clock in four.
    gate = 4;
    w0 = wr_cnt; a0 = act_cnt;
    push_page(8'hC0, 160);
    do_step(1'b1, 8'hC0);
    t0 = clk_cnt;
    run_until_idle(400);
    check("gate_clks", clk_cnt - t0, 32'd644);
    check("gate_writes", wr_cnt - w0, 32'd160);
    check("gate_active_steps", act_cnt - a0, 32'd161);
    check("gate_sb_empty", 32'(sb.size()), 32'd0);
    gate = 1;

    // Restart after 50 writes from page 80 into page 90.
    w0 = wr_cnt; a0 = act_cnt;
    push_page(8'h80, 50);
    do_step(1'b1, 8'h80);
    run_until_writes(w0 + 50, 200);
    push_page(8'h90, 160);
    do_step(1'b1, 8'h90);
    check("restart_no_wr", 32'(last_wr), 32'd0);
    check("restart_active", 32'(bus.active), 32'd1);
    do_step(1'b0, 8'h00);
    check("restart_start_no_wr", 32'(last_wr), 32'd0);
    run_until_idle(400);
    check("restart_writes", wr_cnt - w0, 32'd210);
    check("restart_active_steps", act_cnt - a0, 32'd213);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-COPY at byte 20.
    w0 = wr_cnt;
    push_page(8'hA0, 20);
    do_step(1'b1, 8'hA0);
    run_until_writes(w0 + 20, 200);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    check("midrst_active", 32'(bus.active), 32'd0);
    check("midrst_src_read", 32'(bus.src_read), 32'd0);
    repeat (20) do_step(1'b0, 8'h00);
    check("midrst_writes", wr_cnt - w0, 32'd20);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // Trigger on the last-byte step is ignored; the next step's trigger is taken.
    w0 = wr_cnt;
    push_page(8'hC0, 160);
    do_step(1'b1, 8'hC0);
    run_until_writes(w0 + 159, 400);
    do_step(1'b1, 8'h80);
    check("last_wr_done", 32'(last_wr), 32'd1);
    check("last_idle", 32'(bus.active), 32'd0);
    push_page(8'hD0, 160);
    do_step(1'b1, 8'hD0);
    check("last_retrigger", 32'(bus.active), 32'd1);
    run_until_idle(400);
    check("last_writes", wr_cnt - w0, 32'd320);
    check("last_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
